temporal_encoder: RTL and testbench
===================================

// Module: temporal_encoder
// PURPOSE
//  Converts N_CH binary values into race-logic spikes, one gamma cycle per accepted vector.
//  A spike rises at phase == value inside a GAMMA_CYCLE_WIDTH-cycle window.
//  Also emits gamma_rst, a 1-cycle clear at the start of each window.
//  Sits directly upstream of the less_than comparators: spikes drive a/b, gamma_rst drives rst.
// PARAMETERS
//  GAMMA_CYCLE_WIDTH  16  aclk cycles per gamma cycle (phases 0..GAMMA_CYCLE_WIDTH-1)
//  PULSE_WIDTH        8   spike high-time in cycles (pulse mode)
//  N_CH               4   number of independent encoder channels
//  VAL_W  $clog2(GAMMA_CYCLE_WIDTH)+1  value width; value >= GAMMA_CYCLE_WIDTH means "no spike" (infinity)
// PORTS
//  aclk       in   1           clock
//  grst       in   1           reset, asynchronous, active-high
//  in_valid   in   1           value vector valid
//  in_ready   out  1           encoder can accept a vector
//  in_vals    in   N_CH*VAL_W  packed values, channel i = [i*VAL_W +: VAL_W]
//  abort      in   1           synchronous cancel of the current gamma cycle
//  gamma_rst  out  1           1-cycle clear pulse to downstream comparators
//  spikes     out  N_CH        temporal outputs, registered
//  phase      out  VAL_W       current phase within the gamma cycle
//  busy       out  1           high in RESET or RUN
// BEHAVIOUR
//  Reset values (grst high): state IDLE; spikes=0, gamma_rst=0, phase=0, busy=0. in_ready=1 once released.
//  FSM: IDLE -> RESET -> RUN -> (RESET | IDLE).
//  - IDLE: in_ready=1. On in_valid&in_ready, latch in_vals -> RESET.
//  - RESET: lasts 1 cycle; gamma_rst=1, spikes=0, phase=0 -> RUN.
//  - RUN: phase increments 0..GAMMA_CYCLE_WIDTH-1, one per cycle.
//    - In the last phase, in_ready=1. On handshake -> RESET (back-to-back, no idle gap); else -> IDLE.
//  in_ready is 0 in RESET and in non-final RUN phases.
//  Latency: handshake at edge E0 -> gamma_rst high in cycle 1 -> phase 0 in cycle 2 -> spike i rises in cycle 2+val_i.
//  Pulse mode: spike i high for phases in [val_i, val_i+PULSE_WIDTH-1] ∩ [0, GAMMA_CYCLE_WIDTH-1].
//  - Pulses are truncated at the end of the window, never carried into the next gamma cycle.
//  - val_i >= GAMMA_CYCLE_WIDTH: spike i stays 0 for the whole window.
//  abort: takes priority over the handshake. Next cycle: state IDLE, spikes=0, phase=0; no gamma_rst issued.
//  grst mid-operation: all outputs clear immediately; latched values are discarded.
//  Per-channel pulse counter width $clog2(PULSE_WIDTH+1); it saturates and does not wrap.
// CONFIGURATION
//  STEP_MODE_EN defined: spike i rises at phase val_i and holds until the last phase.
//  - This suits edge-based comparators. PULSE_WIDTH is ignored.
//  STEP_MODE_EN undefined: pulse mode as above.
//  Both modes: spikes forced to 0 in RESET and IDLE.
// STRUCTURE
//  Package temporal_pkg:
//  - enc_state_e {IDLE, RESET, RUN}
//  - localparam-derived phase_t
//  - NO_SPIKE constant
//  Sub-module spike_gen (one per channel), in generate loop. Inputs: phase, start strobe, last strobe, value. Output: spike.
//  - Contains the pulse counter and the STEP_MODE_EN mux.
//  Top level holds the FSM, phase counter, value register and handshake.
// TESTING (GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8, cycles counted after handshake edge E0)
//  1. val0=3 -> gamma_rst in cycle 1; spikes[0] high cycles 5..12, low from 13.
//  2. val1=12 -> spikes[1] high cycles 14..17 (truncated to 4), low in cycle 18.
//  3. val2=16 (no spike) -> spikes[2]=0 throughout; other channels unaffected.
//  4. STEP_MODE_EN, val0=3 -> spikes[0] high cycles 5..17; 0 in cycle 18.
//  5. in_valid held across two vectors -> second accepted at end of cycle 17.
//     gamma_rst in cycle 18; phase 0 in cycle 19; no IDLE cycle between.
//  6. grst pulse in cycle 8 -> spikes/phase/busy 0 asynchronously; in_ready=1 after release.
//     abort in cycle 8 -> spikes=0 and IDLE in cycle 9; no gamma_rst.

Source files
------------

// File: rtl/temporal_encoder_pkg.sv
// Shared types and default geometry for the race-logic temporal encoder.
// STEP_MODE_EN (optional macro) selects step spikes instead of fixed-width pulses.
package temporal_pkg;

  localparam int GAMMA_CYCLE_WIDTH = 16;
  localparam int PULSE_WIDTH       = 8;
  localparam int N_CH              = 4;
  localparam int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1;
  localparam int CNT_W             = $clog2(PULSE_WIDTH + 1);

  typedef logic [VAL_W-1:0] phase_t;

  // Any value at or above the window length never matches a phase.
  localparam phase_t NO_SPIKE   = phase_t'(GAMMA_CYCLE_WIDTH);
  localparam phase_t LAST_PHASE = phase_t'(GAMMA_CYCLE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2
  } enc_state_e;

endpackage

// File: rtl/temporal_encoder_spike_gen.sv
// Per-channel spike generator: raises its spike when the upcoming phase equals its value.
// STEP_MODE_EN defined: spike holds to the end of the window; otherwise a saturating pulse.
module spike_gen
  import temporal_pkg::*;
#(
  parameter int PW = PULSE_WIDTH,
  parameter int VW = VAL_W
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic [VW-1:0] phase,
  input  logic          start,
  input  logic          last,
  input  logic          active,
  input  logic          clear,
  input  logic [VW-1:0] value,
  output logic          spike
);

  localparam int CW = $clog2(PW + 1);

  logic [VW-1:0] phase_next;
  logic          advance;
  logic          hit;
  logic          hold_ok;
  logic          spike_reg;
  logic [CW-1:0] cnt_reg;

  // The spike register is updated together with the phase register, so it
  // is compared against the phase that will be visible next cycle.
  assign phase_next = start ? '0 : phase + VW'(1);
  assign advance    = !clear && (start || (active && !last));
  assign hit        = (value == phase_next);

`ifdef STEP_MODE_EN
  assign hold_ok = 1'b1;
`else
  assign hold_ok = (cnt_reg != CW'(PW));
`endif

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      spike_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (!advance) begin
      spike_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (hit) begin
      spike_reg <= 1'b1;
      cnt_reg   <= CW'(1);
    end else if (spike_reg && hold_ok) begin
      spike_reg <= 1'b1;
      if (cnt_reg != CW'(PW))
        cnt_reg <= cnt_reg + CW'(1);
    end else begin
      spike_reg <= 1'b0;
    end
  end

  assign spike = spike_reg;

endmodule

// File: rtl/temporal_encoder.sv
// Temporal (race-logic) encoder: one gamma window per accepted value vector.
// STEP_MODE_EN (optional macro, in spike_gen) switches all channels to step spikes.
module temporal_encoder
  import temporal_pkg::*;
(
  input  logic                  aclk,
  input  logic                  grst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_CH*VAL_W-1:0] in_vals,
  input  logic                  abort,
  output logic                  gamma_rst,
  output logic [N_CH-1:0]       spikes,
  output logic [VAL_W-1:0]      phase,
  output logic                  busy
);

  enc_state_e            state_reg;
  phase_t                phase_reg;
  logic [N_CH*VAL_W-1:0] vals_reg;
  logic                  last_phase;
  logic                  accept;

  assign last_phase = (state_reg == RUN) && (phase_reg == LAST_PHASE);
  assign in_ready   = (state_reg == IDLE) || last_phase;
  assign accept     = in_valid && in_ready && !abort;

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      vals_reg  <= '0;
    end else if (abort) begin
      state_reg <= IDLE;
      phase_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          phase_reg <= '0;
          if (accept) begin
            vals_reg  <= in_vals;
            state_reg <= RESET;
          end
        end
        RESET: begin
          phase_reg <= '0;
          state_reg <= RUN;
        end
        RUN: begin
          if (last_phase) begin
            phase_reg <= '0;
            if (accept) begin
              vals_reg  <= in_vals;
              state_reg <= RESET;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            phase_reg <= phase_reg + phase_t'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          phase_reg <= '0;
        end
      endcase
    end
  end

  assign gamma_rst = (state_reg == RESET);
  assign busy      = (state_reg != IDLE);
  assign phase     = phase_reg;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      spike_gen #(
        .PW(PULSE_WIDTH),
        .VW(VAL_W)
      ) u_spike_gen (
        .aclk   (aclk),
        .grst   (grst),
        .phase  (phase_reg),
        .start  (state_reg == RESET),
        .last   (last_phase),
        .active (state_reg == RUN),
        .clear  (abort),
        .value  (vals_reg[gi*VAL_W +: VAL_W]),
        .spike  (spikes[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench for temporal_encoder; expectations follow the cycle numbering after handshake edge E0.
// Honors STEP_MODE_EN to select step-mode expected spike end cycles.
module tb_temporal_encoder;
  import temporal_pkg::*;

  localparam int VW = VAL_W;
  localparam int NC = N_CH;
`ifdef STEP_MODE_EN
  localparam int END0 = 17;
  localparam int END3 = 17;
`else
  localparam int END0 = 12;
  localparam int END3 = 9;
`endif

  logic              aclk = 1'b0;
  logic              grst;
  logic              in_valid;
  logic              in_ready;
  logic [NC*VW-1:0]  in_vals;
  logic              abort;
  logic              gamma_rst;
  logic [NC-1:0]     spikes;
  logic [VW-1:0]     phase;
  logic              busy;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [NC-1:0] s_spk  [0:47];
  logic          s_grst [0:47];
  logic          s_rdy  [0:47];
  logic          s_busy [0:47];
  logic [VW-1:0] s_ph   [0:47];

  temporal_encoder dut (
    .aclk      (aclk),
    .grst      (grst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vals   (in_vals),
    .abort     (abort),
    .gamma_rst (gamma_rst),
    .spikes    (spikes),
    .phase     (phase),
    .busy      (busy)
  );

  always #5 aclk = ~aclk;

  function automatic logic [NC*VW-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
    pack4 = {VW'(v3), VW'(v2), VW'(v1), VW'(v0)};
  endfunction

  // Records outputs for cycles 1..n; optionally holds in_valid with vals_b until cycle hold_until.
  task automatic capture(input int n, input int hold_until, input logic [NC*VW-1:0] vals_b);
    if (hold_until > 0) begin
      in_valid = 1'b1;
      in_vals  = vals_b;
    end
    for (int c = 1; c <= n; c++) begin
      s_spk[c]  = spikes;
      s_grst[c] = gamma_rst;
      s_rdy[c]  = in_ready;
      s_busy[c] = busy;
      s_ph[c]   = phase;
      @(posedge aclk); #1;
      if (c == hold_until) in_valid = 1'b0;
    end
  endtask

  task automatic handshake(input logic [NC*VW-1:0] vals);
    in_valid = 1'b1;
    in_vals  = vals;
    @(posedge aclk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (20) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    grst = 1'b1; in_valid = 1'b0; abort = 1'b0; in_vals = '0;
    repeat (2) @(posedge aclk);
    #1;
    total_cnt++; if (spikes !== '0) $display("FAIL reset_spikes got %b exp 0", spikes); else pass_cnt++;
    total_cnt++; if (phase !== '0) $display("FAIL reset_phase got %0d exp 0", phase); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (gamma_rst !== 1'b0) $display("FAIL reset_gamma_rst got %b exp 0", gamma_rst); else pass_cnt++;
    grst = 1'b0;
    @(posedge aclk); #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
    $display("reset: done");
  endtask

  task automatic test_pulse();
    int hits2;
    handshake(pack4(3, 12, 16, 0));
    capture(20, 0, '0);
    total_cnt++; if (s_grst[1] !== 1'b1) $display("FAIL grst_c1 got %b exp 1", s_grst[1]); else pass_cnt++;
    total_cnt++; if (s_grst[2] !== 1'b0) $display("FAIL grst_c2 got %b exp 0", s_grst[2]); else pass_cnt++;
    total_cnt++; if (s_busy[1] !== 1'b1) $display("FAIL busy_c1 got %b exp 1", s_busy[1]); else pass_cnt++;
    total_cnt++; if (s_rdy[1] !== 1'b0) $display("FAIL rdy_c1 got %b exp 0", s_rdy[1]); else pass_cnt++;
    total_cnt++; if (s_ph[2] !== VW'(0)) $display("FAIL phase_c2 got %0d exp 0", s_ph[2]); else pass_cnt++;
    total_cnt++; if (s_ph[5] !== VW'(3)) $display("FAIL phase_c5 got %0d exp 3", s_ph[5]); else pass_cnt++;
    total_cnt++; if (s_ph[17] !== VW'(15)) $display("FAIL phase_c17 got %0d exp 15", s_ph[17]); else pass_cnt++;
    total_cnt++; if (s_spk[4][0] !== 1'b0) $display("FAIL ch0_c4 got %b exp 0", s_spk[4][0]); else pass_cnt++;
    total_cnt++; if (s_spk[5][0] !== 1'b1) $display("FAIL ch0_rise_c5 got %b exp 1", s_spk[5][0]); else pass_cnt++;
    total_cnt++; if (s_spk[END0][0] !== 1'b1) $display("FAIL ch0_end_c%0d got %b exp 1", END0, s_spk[END0][0]); else pass_cnt++;
    total_cnt++; if (s_spk[END0+1][0] !== 1'b0) $display("FAIL ch0_fall_c%0d got %b exp 0", END0+1, s_spk[END0+1][0]); else pass_cnt++;
    total_cnt++; if (s_spk[13][1] !== 1'b0) $display("FAIL ch1_c13 got %b exp 0", s_spk[13][1]); else pass_cnt++;
    total_cnt++; if (s_spk[14][1] !== 1'b1) $display("FAIL ch1_rise_c14 got %b exp 1", s_spk[14][1]); else pass_cnt++;
    total_cnt++; if (s_spk[17][1] !== 1'b1) $display("FAIL ch1_c17 got %b exp 1", s_spk[17][1]); else pass_cnt++;
    total_cnt++; if (s_spk[18][1] !== 1'b0) $display("FAIL ch1_trunc_c18 got %b exp 0", s_spk[18][1]); else pass_cnt++;
    hits2 = 0;
    for (int c = 1; c <= 20; c++) if (s_spk[c][2] !== 1'b0) hits2++;
    total_cnt++; if (hits2 !== 0) $display("FAIL ch2_nospike got %0d high cycles exp 0", hits2); else pass_cnt++;
    total_cnt++; if (s_spk[2][3] !== 1'b1) $display("FAIL ch3_rise_c2 got %b exp 1", s_spk[2][3]); else pass_cnt++;
    total_cnt++; if (s_spk[END3][3] !== 1'b1) $display("FAIL ch3_end_c%0d got %b exp 1", END3, s_spk[END3][3]); else pass_cnt++;
    total_cnt++; if (s_spk[END3+1][3] !== 1'b0) $display("FAIL ch3_fall_c%0d got %b exp 0", END3+1, s_spk[END3+1][3]); else pass_cnt++;
    total_cnt++; if (s_rdy[16] !== 1'b0) $display("FAIL rdy_c16 got %b exp 0", s_rdy[16]); else pass_cnt++;
    total_cnt++; if (s_rdy[17] !== 1'b1) $display("FAIL rdy_last_c17 got %b exp 1", s_rdy[17]); else pass_cnt++;
    total_cnt++; if (s_rdy[18] !== 1'b1) $display("FAIL rdy_idle_c18 got %b exp 1", s_rdy[18]); else pass_cnt++;
    total_cnt++; if (s_busy[18] !== 1'b0) $display("FAIL busy_idle_c18 got %b exp 0", s_busy[18]); else pass_cnt++;
    total_cnt++; if (s_ph[18] !== VW'(0)) $display("FAIL phase_idle_c18 got %0d exp 0", s_ph[18]); else pass_cnt++;
    $display("pulse: vector 3/12/16/0 done");
    drain();
  endtask

  task automatic test_back_to_back();
    int early_rst;
    int idle_gap;
    handshake(pack4(3, 16, 16, 16));
    capture(22, 17, pack4(1, 16, 16, 16));
    early_rst = 0;
    for (int c = 2; c <= 17; c++) if (s_grst[c] !== 1'b0) early_rst++;
    idle_gap = 0;
    for (int c = 1; c <= 22; c++) if (s_busy[c] !== 1'b1) idle_gap++;
    total_cnt++; if (early_rst !== 0) $display("FAIL b2b_early_accept got %0d gamma_rst cycles exp 0", early_rst); else pass_cnt++;
    total_cnt++; if (s_spk[3][0] !== 1'b0) $display("FAIL b2b_first_vec_c3 got %b exp 0", s_spk[3][0]); else pass_cnt++;
    total_cnt++; if (s_spk[5][0] !== 1'b1) $display("FAIL b2b_first_vec_c5 got %b exp 1", s_spk[5][0]); else pass_cnt++;
    total_cnt++; if (s_grst[18] !== 1'b1) $display("FAIL b2b_grst_c18 got %b exp 1", s_grst[18]); else pass_cnt++;
    total_cnt++; if (s_grst[19] !== 1'b0) $display("FAIL b2b_grst_c19 got %b exp 0", s_grst[19]); else pass_cnt++;
    total_cnt++; if (s_ph[19] !== VW'(0)) $display("FAIL b2b_phase_c19 got %0d exp 0", s_ph[19]); else pass_cnt++;
    total_cnt++; if (s_spk[19][0] !== 1'b0) $display("FAIL b2b_ch0_c19 got %b exp 0", s_spk[19][0]); else pass_cnt++;
    total_cnt++; if (s_spk[20][0] !== 1'b1) $display("FAIL b2b_ch0_c20 got %b exp 1", s_spk[20][0]); else pass_cnt++;
    total_cnt++; if (idle_gap !== 0) $display("FAIL b2b_idle_gap got %0d idle cycles exp 0", idle_gap); else pass_cnt++;
    $display("back_to_back: second vector accepted at cycle 17");
    drain();
  endtask

  task automatic test_grst_mid();
    int leftover;
    handshake(pack4(3, 16, 16, 16));
    capture(7, 0, '0);
    total_cnt++; if (spikes[0] !== 1'b1) $display("FAIL grst_pre_ch0 got %b exp 1", spikes[0]); else pass_cnt++;
    grst = 1'b1;
    #1;
    total_cnt++; if (spikes !== '0) $display("FAIL grst_async_spikes got %b exp 0", spikes); else pass_cnt++;
    total_cnt++; if (phase !== '0) $display("FAIL grst_async_phase got %0d exp 0", phase); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL grst_async_busy got %b exp 0", busy); else pass_cnt++;
    #3;
    grst = 1'b0;
    @(posedge aclk); #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL grst_release_rdy got %b exp 1", in_ready); else pass_cnt++;
    capture(20, 0, '0);
    leftover = 0;
    for (int c = 1; c <= 20; c++) if (s_spk[c] !== '0 || s_grst[c] !== 1'b0 || s_busy[c] !== 1'b0) leftover++;
    total_cnt++; if (leftover !== 0) $display("FAIL grst_discard got %0d active cycles exp 0", leftover); else pass_cnt++;
    $display("grst_mid: reset at cycle 8 done");
  endtask

  task automatic test_abort();
    int stray_rst;
    handshake(pack4(3, 16, 16, 16));
    capture(7, 0, '0);
    abort = 1'b1;
    @(posedge aclk); #1;
    abort = 1'b0;
    total_cnt++; if (spikes !== '0) $display("FAIL abort_spikes got %b exp 0", spikes); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (phase !== '0) $display("FAIL abort_phase got %0d exp 0", phase); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL abort_rdy got %b exp 1", in_ready); else pass_cnt++;
    capture(5, 0, '0);
    stray_rst = 0;
    for (int c = 1; c <= 5; c++) if (s_grst[c] !== 1'b0) stray_rst++;
    total_cnt++; if (gamma_rst !== 1'b0 || stray_rst !== 0) $display("FAIL abort_no_grst got %0d exp 0", stray_rst); else pass_cnt++;
    // abort must win over a simultaneous handshake
    abort = 1'b1; in_valid = 1'b1; in_vals = pack4(0, 0, 0, 0);
    @(posedge aclk); #1;
    abort = 1'b0; in_valid = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_priority_busy got %b exp 0", busy); else pass_cnt++;
    $display("abort: cancel at cycle 8 done");
    drain();
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_back_to_back();
    test_grst_mid();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
